// File: rtl/infer_batch_host_pkg.sv
// Shared types and constants for the batch inference host and its watchdog.
package infer_batch_host_pkg;

    localparam int DIGIT_W           = 4;
    localparam int NOMINAL_INFER_CYC = 840;
    // Default timeout: 2x headroom over a nominal inference, rounded up to a power of two
    localparam int DEF_TIMEOUT_CYC   = 1 << $clog2(2 * NOMINAL_INFER_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_RELEASE,
        S_DRAIN,
        S_FINISH,
        S_ERROR
    } state_t;

endpackage

// File: rtl/infer_batch_host_if.sv
// start/done/busy handshake between the batch host (master) and the inference core (slave).
interface infer_batch_host_if;
    import infer_batch_host_pkg::*;

    logic               core_start;
    logic               core_busy;
    logic               core_done;
    logic [DIGIT_W-1:0] core_pred;

    modport master (output core_start, input core_busy, core_done, core_pred);
    modport slave  (input core_start, output core_busy, core_done, core_pred);

endinterface

// File: rtl/infer_watchdog.sv
// Cycle watchdog: counts while enabled, saturates and flags when TIMEOUT_CYC-1 is reached.
module infer_watchdog #(
    parameter int TIMEOUT_CYC = 2048,
    parameter int TMO_W       = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    assign expired = (cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (en && !expired)  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/infer_batch_host.sv
// Batch host: walks NUM_IMG images through the inference core, scores predictions
// against the label ROM and guards every handshake phase with a watchdog.
module infer_batch_host
    import infer_batch_host_pkg::*;
#(
    parameter int NUM_IMG     = 100,
    parameter int IDX_W       = 7,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TMO_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 abort,
    infer_batch_host_if.master   core,
    output logic [IDX_W-1:0]     img_idx,
    input  logic [DIGIT_W-1:0]   label,
    output logic [DIGIT_W-1:0]   pred_out,
    output logic                 pred_valid,
    output logic [IDX_W:0]       img_cnt,
    output logic [IDX_W:0]       correct_cnt,
    output logic                 batch_done,
    output logic                 err_timeout,
    output logic                 active
);

    state_t             state, nxt;
    logic               start_q, start_d;
    logic [IDX_W-1:0]   idx_d;
    logic [DIGIT_W-1:0] pred_d;
    logic               pv_d;
    logic [IDX_W:0]     cnt_d, cor_d;
    logic               wd_clr, wd_en, wd_expired;
    logic               core_idle;

    assign core.core_start = start_q;
    assign core_idle       = !core.core_done && !core.core_busy;

    infer_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .TMO_W(TMO_W)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        nxt     = state;
        start_d = start_q;
        idx_d   = img_idx;
        pred_d  = pred_out;
        pv_d    = 1'b0;
        cnt_d   = img_cnt;
        cor_d   = correct_cnt;
        wd_en   = 1'b0;
        case (state)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (run) begin
                    idx_d = '0;
                    cnt_d = '0;
                    cor_d = '0;
                    nxt   = S_SETUP;
                end
            end
            S_SETUP: nxt = S_START;
            S_START: begin
                start_d = 1'b1;
                nxt     = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (core.core_done) begin
                    pred_d  = core.core_pred;
                    pv_d    = 1'b1;
                    cnt_d   = img_cnt + 1'b1;
                    if (core.core_pred == label) cor_d = correct_cnt + 1'b1;
                    start_d = 1'b0;
                    nxt     = S_RELEASE;
                end else if (wd_expired) begin
                    start_d = 1'b0;
                    nxt     = S_ERROR;
                end
            end
            S_RELEASE: begin
                wd_en = 1'b1;
                if (core_idle) begin
                    if (img_cnt == (IDX_W+1)'(NUM_IMG)) begin
                        nxt = S_FINISH;
                    end else begin
                        idx_d = img_idx + 1'b1;
                        nxt   = S_SETUP;
                    end
                end else if (wd_expired) begin
                    nxt = S_ERROR;
                end
            end
            S_DRAIN: begin
                wd_en = 1'b1;
                if (core_idle)       nxt = S_IDLE;
                else if (wd_expired) nxt = S_ERROR;
            end
            default: nxt = S_IDLE;
        endcase
        // Abort overrides everything above, including a done arriving in the same cycle
        if (abort && (state inside {S_SETUP, S_START, S_WAIT, S_RELEASE})) begin
            start_d = 1'b0;
            idx_d   = img_idx;
            pred_d  = pred_out;
            pv_d    = 1'b0;
            cnt_d   = img_cnt;
            cor_d   = correct_cnt;
            nxt     = S_DRAIN;
        end
        wd_clr = (nxt != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            img_idx     <= '0;
            pred_out    <= '0;
            pred_valid  <= 1'b0;
            img_cnt     <= '0;
            correct_cnt <= '0;
            batch_done  <= 1'b0;
            err_timeout <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= nxt;
            start_q     <= start_d;
            img_idx     <= idx_d;
            pred_out    <= pred_d;
            pred_valid  <= pv_d;
            img_cnt     <= cnt_d;
            correct_cnt <= cor_d;
            batch_done  <= (nxt == S_FINISH);
            err_timeout <= (nxt == S_ERROR);
            active      <= !(nxt inside {S_IDLE, S_FINISH, S_ERROR});
        end
    end

endmodule

// File: tb/tb_infer_batch_host.sv
// Bench for infer_batch_host: responder core model, label ROM, phase-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_infer_batch_host;
    import infer_batch_host_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int T  = 64;
    localparam int TW = 7;

    localparam int P_IDLE = 0, P_SETUP = 1, P_START = 2, P_WAIT = 3,
                   P_REL = 4, P_DRAIN = 5, P_FIN = 6, P_ERR = 7;

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, abort = 1'b0;
    logic [IW-1:0] img_idx;
    logic [3:0]    label, pred_out;
    logic          pred_valid, batch_done, err_timeout, active;
    logic [IW:0]   img_cnt, correct_cnt;

    infer_batch_host_if bus();

    infer_batch_host #(.NUM_IMG(N), .IDX_W(IW), .TIMEOUT_CYC(T), .TMO_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .abort       (abort),
        .core        (bus),
        .img_idx     (img_idx),
        .label       (label),
        .pred_out    (pred_out),
        .pred_valid  (pred_valid),
        .img_cnt     (img_cnt),
        .correct_cnt (correct_cnt),
        .batch_done  (batch_done),
        .err_timeout (err_timeout),
        .active      (active)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, pv_seen = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- label ROM (one-cycle read latency) ----------------
    logic [3:0] rom [4];
    always @(posedge clk) label <= rom[img_idx];

    // ---------------- responder core model ----------------
    bit         rmode = 1'b0, k_hang = 1'b0;
    int         k_lat = 30, k_tail = 2;
    logic [3:0] k_wrong = 4'b0010;
    logic       busy_r, done_r, cs_q, comp;
    logic [3:0] pred_r;
    logic [IW-1:0] cidx;
    int         ccnt, tcnt;

    assign bus.core_busy = busy_r;
    assign bus.core_done = done_r;
    assign bus.core_pred = pred_r;

    function automatic int tail_len();
        return rmode ? int'($urandom_range(0, 3)) : k_tail;
    endfunction

    function automatic logic [3:0] pick(input logic [IW-1:0] i);
        if (rmode) return ($urandom % 2 == 0) ? rom[i] : 4'($urandom % 16);
        return k_wrong[i] ? 4'((rom[i] + 1) % 10) : rom[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= 1'b0; comp <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
            pred_r <= '0; cidx <= '0; ccnt <= 0; tcnt <= 0;
        end else begin
            cs_q <= bus.core_start;
            if (bus.core_start && !cs_q) begin
                comp   <= 1'b1;
                busy_r <= 1'b1;
                done_r <= 1'b0;
                cidx   <= img_idx;
                ccnt   <= rmode ? int'($urandom_range(1, 70)) : k_lat;
            end else if (comp) begin
                if (!bus.core_start) begin
                    comp <= 1'b0;
                    tcnt <= tail_len();
                end else if (ccnt <= 1 && !k_hang) begin
                    comp   <= 1'b0;
                    done_r <= 1'b1;
                    pred_r <= pick(cidx);
                    tcnt   <= tail_len();
                end else begin
                    ccnt <= ccnt - 1;
                end
            end else begin
                if (done_r && !bus.core_start) done_r <= 1'b0;
                if (busy_r) begin
                    if (tcnt == 0) busy_r <= 1'b0;
                    else           tcnt   <= tcnt - 1;
                end
            end
        end
    end

    // ---------------- reference model: phase + cycles spent in phase ----------------
    int          ph, age;
    logic        m_start, m_pv;
    logic [IW-1:0] m_idx;
    logic [IW:0] m_cnt, m_cor;
    logic [3:0]  m_pred;

    initial forever begin
        int nph;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = P_IDLE; age = 0; m_start = 0; m_pv = 0;
            m_idx = 0; m_cnt = 0; m_cor = 0; m_pred = 0;
        end else begin
            nph  = ph;
            m_pv = 0;
            age++;
            if (ph == P_IDLE || ph == P_FIN || ph == P_ERR) begin
                if (run) begin m_idx = 0; m_cnt = 0; m_cor = 0; nph = P_SETUP; end
            end else if (abort && ph != P_DRAIN) begin
                m_start = 0; nph = P_DRAIN;
            end else if (ph == P_SETUP) begin
                nph = P_START;
            end else if (ph == P_START) begin
                m_start = 1; nph = P_WAIT;
            end else if (ph == P_WAIT) begin
                if (bus.core_done) begin
                    m_pred = bus.core_pred; m_pv = 1; m_cnt++;
                    if (bus.core_pred == label) m_cor++;
                    m_start = 0; nph = P_REL;
                end else if (age == T) begin
                    m_start = 0; nph = P_ERR;
                end
            end else begin
                if (!bus.core_done && !bus.core_busy) begin
                    if (ph == P_DRAIN)    nph = P_IDLE;
                    else if (m_cnt == N)  nph = P_FIN;
                    else begin m_idx++; nph = P_SETUP; end
                end else if (age == T) begin
                    nph = P_ERR;
                end
            end
            if (nph != ph) age = 0;
            ph = nph;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_start = 1'b0;
    initial forever begin
        logic act;
        @(negedge clk);
        if (rst_n) begin
            act = !(ph == P_IDLE || ph == P_FIN || ph == P_ERR);
            check("cycle",
                  {15'd0, bus.core_start, img_idx, pred_out, pred_valid, img_cnt, correct_cnt,
                   batch_done, err_timeout, active},
                  {15'd0, m_start, m_idx, m_pred, m_pv, m_cnt, m_cor,
                   (ph == P_FIN), (ph == P_ERR), act});
            if (bus.core_start && !prev_start) check("start_rise_done_low", bus.core_done, 0);
            if (pred_valid) pv_seen++;
        end
        prev_start = bus.core_start;
    end

    // ---------------- directed scenarios ----------------
    function automatic bit cond(input int w);
        case (w)
            0: return batch_done;
            1: return !active;
            2: return bus.core_start;
            3: return err_timeout;
            4: return bus.core_done;
            5: return img_cnt == 1 && bus.core_start && bus.core_busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w, input int maxc, output int n);
        n = 0;
        while (!cond(w)) begin
            if (n >= maxc) begin
                checks++; errors++;
                $display("FAIL %s got=waited %0d cycles exp=condition reached", nm, n);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    logic [16:0] outs;
    assign outs = {bus.core_start, img_idx, pred_out, pred_valid, img_cnt, correct_cnt,
                   batch_done, err_timeout, active};

    initial begin
        int n;
        for (int i = 0; i < 4; i++) rom[i] = 4'($urandom_range(0, 9));
        #1 check("reset_outputs", outs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // nominal batch: image 1 mispredicted
        pv_seen = 0;
        pulse_run();
        wait_for("batch1_done", 0, 1000, n);
        check("batch1_img_cnt", img_cnt, 3);
        check("batch1_correct", correct_cnt, 2);
        check("batch1_img_idx", img_idx, 2);
        check("batch1_done_flag", batch_done, 1);
        check("batch1_pv_pulses", pv_seen, 3);

        // done on the last cycle the watchdog allows
        k_lat = 62; k_wrong = 4'b0000;
        pulse_run();
        wait_for("lat62_done", 0, 1000, n);
        check("lat62_correct", correct_cnt, 3);
        check("lat62_err", err_timeout, 0);

        // core that never answers
        k_hang = 1'b1;
        pulse_run();
        wait_for("hang_start", 2, 50, n);
        wait_for("hang_err", 3, 200, n);
        check("timeout_cycles", n, 64);
        check("timeout_core_start", bus.core_start, 0);
        check("timeout_img_cnt", img_cnt, 0);
        k_hang = 1'b0; k_lat = 10;
        pulse_run();
        check("restart_err_clear", err_timeout, 0);
        check("restart_img_idx", img_idx, 0);
        wait_for("restart_done", 0, 1000, n);

        // one cycle too slow
        k_lat = 63;
        pulse_run();
        wait_for("lat63_err", 3, 500, n);
        check("lat63_err_flag", err_timeout, 1);

        // abort while image 1 is in flight
        k_lat = 40; k_wrong = 4'b0010;
        pulse_run();
        wait_for("img1_wait", 5, 500, n);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_start_low", bus.core_start, 0);
        wait_for("abort_drain", 1, 100, n);
        check("abort_img_cnt", img_cnt, 1);
        check("abort_active", active, 0);
        check("abort_batch_done", batch_done, 0);

        // abort in the same cycle the core reports done
        k_lat = 15;
        pulse_run();
        wait_for("abort_done_wait", 4, 500, n);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_done_pv", pred_valid, 0);
        check("abort_done_img_cnt", img_cnt, 0);
        check("abort_done_correct", correct_cnt, 0);
        wait_for("abort_done_idle", 1, 100, n);

        // asynchronous reset between edges mid-WAIT
        pulse_run();
        wait_for("rst_wait", 2, 50, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs, 0);
        @(negedge clk) rst_n = 1'b1;
        k_wrong = 4'b0000;
        pulse_run();
        wait_for("post_rst_done", 0, 1000, n);
        check("post_rst_img_cnt", img_cnt, 3);
        check("post_rst_correct", correct_cnt, 3);

        // randomized run/abort against a random-latency core
        rmode = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            run   = ($urandom % 30 == 0);
            abort = ($urandom % 250 == 0);
        end
        @(negedge clk);
        run = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/infer_batch_host.md
Name: infer_batch_host

Overview:
- Host-side initiator for the inference core's start/done/busy handshake; the core itself is the responder.
- Steps through a batch of stored images: selects each image index, runs one full inference per image, and captures the predicted digit.
- Compares each prediction against a label ROM and keeps running statistics.
- Sits between the board-level run/abort controls (buttons/LEDs) and the inference core; guards each inference with a watchdog timeout.

Parameters:
- NUM_IMG, 100, number of images per batch (≥1).
- IDX_W, 7, width of img_idx; 2^IDX_W ≥ NUM_IMG.
- TIMEOUT_CYC, 2048, max cycles allowed in WAIT or RELEASE before an error (nominal inference is about 840 cycles).
- TMO_W, 12, watchdog counter width; 2^TMO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  one-cycle pulse; starts a batch from IDLE, FINISH or ERROR
- abort  in  1  level/pulse; cancels the batch in progress
- core_start  out  1  start request to the core, registered
- core_busy  in  1  core busy status
- core_done  in  1  core done status, held by the core until start falls
- core_pred  in  4  core argmax result, valid while core_done=1
- img_idx  out  IDX_W  image/label select to image memory and label ROM
- label  in  4  label for img_idx, valid 1 cycle after img_idx changes
- pred_out  out  4  last captured prediction
- pred_valid  out  1  one-cycle pulse when pred_out updates
- img_cnt  out  IDX_W+1  images completed in this batch
- correct_cnt  out  IDX_W+1  predictions equal to label
- batch_done  out  1  held high in FINISH
- err_timeout  out  1  held high in ERROR
- active  out  1  high in any state except IDLE, FINISH, ERROR

Behaviour:
- Reset (async, rst_n=0): every output is 0 immediately; state=IDLE; watchdog=0.
- All outputs are registered.
- States: IDLE, SETUP, START, WAIT, RELEASE, DRAIN, FINISH, ERROR.
- IDLE/FINISH/ERROR, on run=1:
  - clear img_idx, img_cnt, correct_cnt, batch_done, err_timeout;
  - go to SETUP.
  - run is ignored in all other states.
- SETUP: exactly one cycle, to cover label/image memory latency; go to START.
- START:
  - core_start<=1, watchdog<=0; go to WAIT.
  - core_start stays 1 through WAIT.
- WAIT:
  - watchdog increments every cycle.
  - On core_done=1:
    - pred_out<=core_pred; pred_valid=1 for that single cycle;
    - img_cnt+1; correct_cnt+1 if core_pred==label (4-bit compare);
    - core_start<=0, watchdog<=0; go to RELEASE.
  - If watchdog reaches TIMEOUT_CYC-1 without done: core_start<=0; go to ERROR.
- RELEASE:
  - Wait for core_done=0 and core_busy=0; the watchdog applies here too.
  - Then, if img_cnt==NUM_IMG: go to FINISH.
  - Otherwise img_idx+1 and go to SETUP.
  - The next core_start therefore never rises while core_done is still high.
- FINISH: batch_done=1, counters frozen.
- ERROR: err_timeout=1, core_start=0, counters frozen.
- abort=1 in SETUP/START/WAIT/RELEASE:
  - core_start<=0; go to DRAIN.
  - abort wins over a simultaneous core_done: no pred_valid, counters unchanged.
- DRAIN:
  - Wait for core_done=0 and core_busy=0, then go to IDLE. Counters are retained.
  - The watchdog applies; on expiry go to ERROR.
- abort in IDLE/FINISH/ERROR: no effect.
- Counter widths: img_cnt and correct_cnt never exceed NUM_IMG, so there is no wrap. img_idx stops at NUM_IMG-1.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - DIGIT_W=4;
  - the nominal inference-cycle constant, used for default TIMEOUT_CYC derivation.
- One natural sub-module: infer_watchdog (a counter with clear, enable and expire flag, parameterised by TIMEOUT_CYC). It is reused in WAIT, RELEASE and DRAIN.

Test Plan:
- NUM_IMG=3; core model answers ~840 cycles after start with pred=label for img 0 and 2 and a wrong pred for img 1 -> three pred_valid pulses, img_cnt=3, correct_cnt=2, batch_done=1, img_idx=2.
- Handshake check with a core model that holds done until start falls -> core_start high from START until the cycle after done; no new rise until core_done=0 and core_busy=0; SETUP lasts exactly 1 cycle.
- TIMEOUT_CYC=64, core never asserts done -> err_timeout=1 exactly 64 cycles after entering WAIT; core_start=0; next run clears it and restarts at img_idx=0.
- abort during WAIT of image 1 (img_cnt=1) -> core_start falls next cycle; DRAIN until the core is idle; then IDLE with img_cnt=1 and active=0.
- abort and core_done in the same cycle -> no pred_valid; img_cnt and correct_cnt unchanged.
- rst_n low mid-WAIT between clock edges -> all outputs 0 immediately (no clock edge); after release, run starts a clean batch.
